// File: rtl/hilo_muldiv_unit.sv
// HI/LO register owner for the EX stage: single-cycle MULT/MULTU, MTHI/MTLO, MFHI/MFLO,
// and an iterative radix-2 restoring divider for DIV/DIVU that stalls the pipeline.
module hilo_muldiv_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        alucontrol_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              stall_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam logic [4:0] MULT_CONTROL  = 5'd10;
    localparam logic [4:0] MULTU_CONTROL = 5'd11;
    localparam logic [4:0] DIV_CONTROL   = 5'd12;
    localparam logic [4:0] DIVU_CONTROL  = 5'd13;
    localparam logic [4:0] MTHI_CONTROL  = 5'd14;
    localparam logic [4:0] MTLO_CONTROL  = 5'd15;
    localparam logic [4:0] MFHI_CONTROL  = 5'd16;
    localparam logic [4:0] MFLO_CONTROL  = 5'd17;

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic [DATA_W-1:0]   dvs;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic [CNT_W-1:0]    count;
    logic                neg_q;
    logic                neg_r;

    logic                issue;
    logic                is_div;
    logic                signed_div;
    logic                div_start;
    logic [DATA_W-1:0]   a_abs;
    logic [DATA_W-1:0]   b_abs;
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   rem_nxt;
    logic [DATA_W-1:0]   quo_nxt;
    logic [DATA_W-1:0]   q_final;
    logic [DATA_W-1:0]   r_final;

    // rst gates issue so stall_o falls immediately on an asynchronous reset even with a DIV held at the input
    assign issue      = valid_i & ~flush_i & ~rst & (state == IDLE);
    assign signed_div = (alucontrol_i == DIV_CONTROL);
    assign is_div     = signed_div | (alucontrol_i == DIVU_CONTROL);
    assign div_start  = issue & is_div & (b_i != '0);
    assign stall_o    = div_start | ((state == BUSY) & ~flush_i & ~rst);

    assign a_abs = (signed_div & a_i[DATA_W-1]) ? -a_i : a_i;
    assign b_abs = (signed_div & b_i[DATA_W-1]) ? -b_i : b_i;

    assign prod_s = {{DATA_W{a_i[DATA_W-1]}}, a_i} * {{DATA_W{b_i[DATA_W-1]}}, b_i};
    assign prod_u = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

    // One restoring step: dividend bits shift out of quo into rem, quotient bits shift in
    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        diff    = shifted - {1'b0, dvs};
        rem_nxt = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
        quo_nxt = {quo[DATA_W-2:0], ~diff[DATA_W]};
        q_final = neg_q ? -quo_nxt : quo_nxt;
        r_final = neg_r ? -rem_nxt : rem_nxt;
    end

    always_comb begin
        result_o = '0;
        if (alucontrol_i == MFHI_CONTROL)      result_o = hi;
        else if (alucontrol_i == MFLO_CONTROL) result_o = lo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            dvs   <= '0;
            quo   <= '0;
            rem   <= '0;
            count <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        case (alucontrol_i)
                            MULT_CONTROL:  {hi, lo} <= prod_s;
                            MULTU_CONTROL: {hi, lo} <= prod_u;
                            MTHI_CONTROL:  hi <= a_i;
                            MTLO_CONTROL:  lo <= a_i;
                            default: ;
                        endcase
                    end
                    if (div_start) begin
                        dvs   <= b_abs;
                        quo   <= a_abs;
                        rem   <= '0;
                        count <= '0;
                        neg_q <= signed_div & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
                        neg_r <= signed_div & a_i[DATA_W-1];
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        rem   <= rem_nxt;
                        quo   <= quo_nxt;
                        count <= count + 1'b1;
                        if (count == LAST_STEP) begin
                            hi    <= r_final;
                            lo    <= q_final;
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign hi_o = hi;
    assign lo_o = lo;

endmodule
